// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_pkg / trap_ctrl_if
//
// Purpose: shared types and CSR addresses for the machine-mode trap
// controller, plus the interface that bundles every trap_ctrl signal except
// clk/rst_n.
//
// Modports:
//   slave  - trap_ctrl side: takes requests and CSR values, drives CSR
//            writes, pipeline control and the privilege level.
//   master - pipeline / CSR-file side (the mirror image of slave).
//
// Signals:
//   exc_valid/exc_code/exc_pc/exc_tval  synchronous exception request
//   irq_valid/irq_cause/irq_pc          interrupt request
//   mret_valid                          mret retiring
//   csr_mstatus/csr_mtvec/csr_mepc      current CSR values
//   csr_we/csr_waddr/csr_wdata          CSR write request
//   csr_wready                          CSR file takes the write this cycle
//   busy/flush/redirect_valid/redirect_pc  pipeline stall, flush, redirect
//   priv_mode                           current privilege (11=M, 00=U)
// -----------------------------------------------------------------------------
package trap_pkg;

  typedef enum logic [3:0] {
    EXC_NONE             = 4'd0,
    EXC_INST_MISALIGNED  = 4'd1,
    EXC_INST_ACCESS      = 4'd2,
    EXC_ILLEGAL_INST     = 4'd3,
    EXC_BREAKPOINT       = 4'd4,
    EXC_LOAD_MISALIGNED  = 4'd5,
    EXC_LOAD_ACCESS      = 4'd6,
    EXC_STORE_MISALIGNED = 4'd7,
    EXC_STORE_ACCESS     = 4'd8,
    EXC_ECALL_U          = 4'd9,
    EXC_ECALL_M          = 4'd11,
    EXC_INST_PAGE_FAULT  = 4'd12,
    EXC_LOAD_PAGE_FAULT  = 4'd13,
    EXC_STORE_PAGE_FAULT = 4'd14
  } exception_code_t;

  typedef enum logic [3:0] {
    NOINTPROCESSING = 4'd0,
    SWINTPROCESSING = 4'd1,
    TRINTPROCESSING = 4'd2,
    EXINTPROCESSING = 4'd3
  } interrupt_trap_cause_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

interface trap_ctrl_if;
  import trap_pkg::*;

  logic                 exc_valid;
  exception_code_t      exc_code;
  logic [63:0]          exc_pc;
  logic [63:0]          exc_tval;
  logic                 irq_valid;
  interrupt_trap_cause_t irq_cause;
  logic [63:0]          irq_pc;
  logic                 mret_valid;
  logic [63:0]          csr_mstatus;
  logic [63:0]          csr_mtvec;
  logic [63:0]          csr_mepc;
  logic                 csr_we;
  logic [11:0]          csr_waddr;
  logic [63:0]          csr_wdata;
  logic                 csr_wready;
  logic                 busy;
  logic                 flush;
  logic                 redirect_valid;
  logic [63:0]          redirect_pc;
  logic [1:0]           priv_mode;

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval,
    input  irq_valid, irq_cause, irq_pc, mret_valid,
    input  csr_mstatus, csr_mtvec, csr_mepc, csr_wready,
    output csr_we, csr_waddr, csr_wdata,
    output busy, flush, redirect_valid, redirect_pc, priv_mode
  );

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval,
    output irq_valid, irq_cause, irq_pc, mret_valid,
    output csr_mstatus, csr_mtvec, csr_mepc, csr_wready,
    input  csr_we, csr_waddr, csr_wdata,
    input  busy, flush, redirect_valid, redirect_pc, priv_mode
  );

endinterface

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Purpose: machine-mode trap sequencer. Takes one exception, interrupt or
// mret while idle, performs the mepc/mcause/mtval/mstatus CSR writes (or the
// single mstatus write for mret) through a ready-gated write port, then
// flushes the pipeline and redirects the PC for exactly one cycle.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - trap_ctrl_if.slave (requests, CSR values, CSR write port,
//            busy/flush/redirect, priv_mode)
//
// Build option:
//   TRAP_VECTORED_EN - when defined, interrupts taken with mtvec[1:0]=01 jump
//                      to base + 4*cause; otherwise every trap goes to base.
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    R_MSTATUS = 3'd5,
    REDIRECT  = 3'd6
  } state_t;

  // Exception code to mcause value (bit63 clear).
  function automatic logic [63:0] exc_mcause(input logic [3:0] code);
    logic [3:0] m;
    case (code)
      EXC_INST_MISALIGNED, EXC_INST_ACCESS, EXC_ILLEGAL_INST, EXC_BREAKPOINT,
      EXC_LOAD_MISALIGNED, EXC_LOAD_ACCESS, EXC_STORE_MISALIGNED,
      EXC_STORE_ACCESS:     m = code - 4'd1;
      EXC_ECALL_U:          m = 4'd8;
      EXC_STORE_PAGE_FAULT: m = 4'd15;
      default:              m = code;
    endcase
    return {60'd0, m};
  endfunction

  // Interrupt cause to mcause value (bit63 set).
  function automatic logic [63:0] irq_mcause(input logic [3:0] cause);
    logic [62:0] m;
    case (cause)
      SWINTPROCESSING: m = 63'd3;
      TRINTPROCESSING: m = 63'd7;
      EXINTPROCESSING: m = 63'd11;
      default:         m = 63'd0;
    endcase
    return {1'b1, m};
  endfunction

  // mstatus after trap entry: MPIE<-MIE, MIE<-0, MPP<-current privilege.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] ms, input logic [1:0] priv);
    logic [63:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = priv;
    return r;
  endfunction

  // mstatus after mret: MIE<-MPIE, MPIE<-1, MPP<-U.
  function automatic logic [63:0] mret_mstatus(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

  // Trap target; vectoring only applies to interrupts (mcause bit63 set).
  function automatic logic [63:0] trap_target(input logic [63:0] mtvec, input logic [63:0] cause);
    logic [63:0] base;
    logic        vec_en;
    base = {mtvec[63:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    vec_en = 1'b1;
`else
    vec_en = 1'b0;
`endif
    if (vec_en && (mtvec[1:0] == 2'b01) && cause[63]) begin
      return base + ({1'b0, cause[62:0]} << 2'd2);
    end else begin
      return base;
    end
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] tval_q, tval_d;
  logic        is_mret_q, is_mret_d;
  logic [1:0]  mpp_q, mpp_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [63:0] csr_wdata_q, csr_wdata_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]  priv_q, priv_d;

  logic        exc_req;
  logic        irq_req;

  // EXC_NONE is not a request; interrupts are masked by mstatus.MIE.
  assign exc_req = bus.exc_valid && (bus.exc_code != EXC_NONE);
  assign irq_req = bus.irq_valid && bus.csr_mstatus[3];

  // Next state, latched trap context and registered outputs.
  // Write address/data are computed on entry to each write state and held
  // (via the _q defaults) until csr_wready lets the sequence advance.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    is_mret_d        = is_mret_q;
    mpp_d            = mpp_q;
    csr_we_d         = csr_we_q;
    csr_waddr_d      = csr_waddr_q;
    csr_wdata_d      = csr_wdata_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    priv_d           = priv_q;
    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d     = W_MEPC;
          pc_d        = bus.exc_pc;
          cause_d     = exc_mcause(bus.exc_code);
          tval_d      = bus.exc_tval;
          is_mret_d   = 1'b0;
          csr_we_d    = 1'b1;
          csr_waddr_d = CSR_MEPC;
          csr_wdata_d = bus.exc_pc;
        end else if (irq_req) begin
          state_d     = W_MEPC;
          pc_d        = bus.irq_pc;
          cause_d     = irq_mcause(bus.irq_cause);
          tval_d      = 64'd0;
          is_mret_d   = 1'b0;
          csr_we_d    = 1'b1;
          csr_waddr_d = CSR_MEPC;
          csr_wdata_d = bus.irq_pc;
        end else if (bus.mret_valid) begin
          state_d     = R_MSTATUS;
          is_mret_d   = 1'b1;
          mpp_d       = bus.csr_mstatus[12:11];
          csr_we_d    = 1'b1;
          csr_waddr_d = CSR_MSTATUS;
          csr_wdata_d = mret_mstatus(bus.csr_mstatus);
        end else begin
          csr_we_d = 1'b0;
        end
      end
      W_MEPC: begin
        if (bus.csr_wready) begin
          state_d     = W_MCAUSE;
          csr_waddr_d = CSR_MCAUSE;
          csr_wdata_d = cause_q;
        end else begin
          state_d = state_q;
        end
      end
      W_MCAUSE: begin
        if (bus.csr_wready) begin
          state_d     = W_MTVAL;
          csr_waddr_d = CSR_MTVAL;
          csr_wdata_d = tval_q;
        end else begin
          state_d = state_q;
        end
      end
      W_MTVAL: begin
        if (bus.csr_wready) begin
          state_d     = W_MSTATUS;
          csr_waddr_d = CSR_MSTATUS;
          csr_wdata_d = trap_mstatus(bus.csr_mstatus, priv_q);
        end else begin
          state_d = state_q;
        end
      end
      W_MSTATUS, R_MSTATUS: begin
        if (bus.csr_wready) begin
          state_d          = REDIRECT;
          csr_we_d         = 1'b0;
          csr_waddr_d      = 12'd0;
          csr_wdata_d      = 64'd0;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = is_mret_q ? bus.csr_mepc : trap_target(bus.csr_mtvec, cause_q);
          priv_d           = is_mret_q ? mpp_q : 2'b11;
        end else begin
          state_d = state_q;
        end
      end
      REDIRECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        csr_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pc_q             <= 64'd0;
      cause_q          <= 64'd0;
      tval_q           <= 64'd0;
      is_mret_q        <= 1'b0;
      mpp_q            <= 2'b00;
      csr_we_q         <= 1'b0;
      csr_waddr_q      <= 12'd0;
      csr_wdata_q      <= 64'd0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
      priv_q           <= 2'b11;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      cause_q          <= cause_d;
      tval_q           <= tval_d;
      is_mret_q        <= is_mret_d;
      mpp_q            <= mpp_d;
      csr_we_q         <= csr_we_d;
      csr_waddr_q      <= csr_waddr_d;
      csr_wdata_q      <= csr_wdata_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      priv_q           <= priv_d;
    end
  end

  assign bus.csr_we         = csr_we_q;
  assign bus.csr_waddr      = csr_waddr_q;
  assign bus.csr_wdata      = csr_wdata_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.priv_mode      = priv_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//
// Scoreboard bench for trap_ctrl. Stimulus pushes the expected CSR writes
// and redirect (with the cycle they must appear in) into a queue; a monitor
// on the falling edge pops and compares whenever the DUT presents an
// accepted CSR write or a redirect. Cycle 0 of a request is the cycle in
// which the bench drives it.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam logic [11:0] RDR = 12'hFFF;  // scoreboard tag for a redirect

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    logic [1:0]  priv;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  exp_t        sbq[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          tmo_cnt = 0;
  bit          done    = 1'b0;
  bit          fin     = 1'b0;
  bit          chk_busy0 = 1'b0;
  bit          hold_chk  = 1'b0;
  logic [11:0] hold_addr = 12'd0;
  logic [63:0] hold_data = 64'd0;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- monitor
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input logic [11:0] a, input logic [63:0] d, input logic [1:0] p);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output: got addr=%h data=%h at cycle %0d, required nothing", a, d, cyc);
    end else begin
      e = sbq.pop_front();
      if (a !== e.addr || d !== e.data || cyc != e.cyc || (a == RDR && p !== e.priv)) begin
        n_bad++;
        $display("FAIL scoreboard: got addr=%h data=%h priv=%b cyc=%0d, required addr=%h data=%h priv=%b cyc=%0d",
                 a, d, p, cyc, e.addr, e.data, e.priv, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("rst_csr_we",      64'(bus.csr_we),         64'd0);
      cmp("rst_busy",        64'(bus.busy),           64'd0);
      cmp("rst_flush",       64'(bus.flush),          64'd0);
      cmp("rst_redirect_v",  64'(bus.redirect_valid), 64'd0);
      cmp("rst_redirect_pc", bus.redirect_pc,         64'd0);
      cmp("rst_waddr",       64'(bus.csr_waddr),      64'd0);
      cmp("rst_wdata",       bus.csr_wdata,           64'd0);
      cmp("rst_priv",        64'(bus.priv_mode),      64'd3);
    end else begin
      if (bus.csr_we && bus.csr_wready) begin
        check_event(bus.csr_waddr, bus.csr_wdata, 2'b00);
      end
      if (bus.redirect_valid) begin
        check_event(RDR, bus.redirect_pc, bus.priv_mode);
        cmp("flush_with_redirect", 64'(bus.flush), 64'd1);
      end
      if (chk_busy0) begin
        cmp("busy_no_accept", 64'(bus.busy), 64'd0);
      end
      if (hold_chk && !bus.csr_wready) begin
        cmp("hold_we",    64'(bus.csr_we),    64'd1);
        cmp("hold_waddr", 64'(bus.csr_waddr), 64'(hold_addr));
        cmp("hold_wdata", bus.csr_wdata,      hold_data);
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      cmp("scoreboard_drained", 64'(sbq.size()), 64'd0);
      cmp("wait_timeouts",      64'(tmo_cnt),    64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [63:0] d, input logic [1:0] p, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.priv = p;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic expect_trap(input int c0, input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] tval, input logic [63:0] mst,
                             input logic [63:0] rpc, input int stall);
    push(12'h341, pc,    2'b00, c0 + 1);
    push(12'h342, cause, 2'b00, c0 + 2 + stall);
    push(12'h343, tval,  2'b00, c0 + 3 + stall);
    push(12'h300, mst,   2'b00, c0 + 4 + stall);
    push(RDR,     rpc,   2'b11, c0 + 5 + stall);
  endtask

  task automatic clr_req();
    bus.exc_valid  = 1'b0;
    bus.exc_code   = EXC_NONE;
    bus.exc_pc     = 64'd0;
    bus.exc_tval   = 64'd0;
    bus.irq_valid  = 1'b0;
    bus.irq_cause  = NOINTPROCESSING;
    bus.irq_pc     = 64'd0;
    bus.mret_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      nxt();
      n++;
    end
    if (bus.busy) begin
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
      tmo_cnt++;
    end
    nxt();
  endtask

  initial begin
    int c0;
    clr_req();
    bus.csr_mstatus = 64'd0;
    bus.csr_mtvec   = 64'd0;
    bus.csr_mepc    = 64'd0;
    bus.csr_wready  = 1'b1;
    repeat (3) nxt();
    rst_n = 1'b1;
    nxt();

    // Illegal instruction, M-mode, MIE=1.
    c0 = cyc;
    bus.csr_mstatus = 64'h8;
    bus.csr_mtvec   = 64'h8000_0100;
    bus.exc_valid   = 1'b1;
    bus.exc_code    = EXC_ILLEGAL_INST;
    bus.exc_pc      = 64'h8000_0010;
    bus.exc_tval    = 64'h1234;
    expect_trap(c0, 64'h8000_0010, 64'd2, 64'h1234, 64'h1880, 64'h8000_0100, 0);
    nxt();
    clr_req();
    wait_idle();

    // mret back to U-mode.
    c0 = cyc;
    bus.csr_mstatus = 64'h80;
    bus.csr_mepc    = 64'h8000_2000;
    bus.mret_valid  = 1'b1;
    push(12'h300, 64'h88, 2'b00, c0 + 1);
    push(RDR, 64'h8000_2000, 2'b00, c0 + 2);
    nxt();
    clr_req();
    wait_idle();

    // Timer interrupt masked (MIE=0) plus an EXC_NONE exception: no accept.
    bus.csr_mstatus = 64'd0;
    bus.irq_valid   = 1'b1;
    bus.irq_cause   = TRINTPROCESSING;
    bus.irq_pc      = 64'h8000_0400;
    bus.exc_valid   = 1'b1;
    bus.exc_code    = EXC_NONE;
    chk_busy0       = 1'b1;
    repeat (4) nxt();
    chk_busy0       = 1'b0;
    clr_req();
    nxt();

    // Timer interrupt with MIE=1 from U-mode.
    c0 = cyc;
    bus.csr_mstatus = 64'h8;
    bus.csr_mtvec   = 64'h8000_0100;
    bus.irq_valid   = 1'b1;
    bus.irq_cause   = TRINTPROCESSING;
    bus.irq_pc      = 64'h8000_0400;
    expect_trap(c0, 64'h8000_0400, 64'h8000_0000_0000_0007, 64'd0, 64'h80, 64'h8000_0100, 0);
    nxt();
    clr_req();
    wait_idle();

    // Exception, interrupt and mret together: exception wins, base target.
    c0 = cyc;
    bus.csr_mstatus = 64'h88;
    bus.csr_mtvec   = 64'h8000_0101;
    bus.csr_mepc    = 64'h8000_2000;
    bus.exc_valid   = 1'b1;
    bus.exc_code    = EXC_ECALL_M;
    bus.exc_pc      = 64'h8000_0200;
    bus.exc_tval    = 64'd0;
    bus.irq_valid   = 1'b1;
    bus.irq_cause   = EXINTPROCESSING;
    bus.irq_pc      = 64'h8000_0999;
    bus.mret_valid  = 1'b1;
    expect_trap(c0, 64'h8000_0200, 64'd11, 64'd0, 64'h1880, 64'h8000_0100, 0);
    nxt();
    clr_req();
    wait_idle();

    // Store page fault with csr_wready low for 3 cycles in W_MCAUSE.
    c0 = cyc;
    bus.csr_mstatus = 64'd0;
    bus.csr_mtvec   = 64'h8000_0100;
    bus.exc_valid   = 1'b1;
    bus.exc_code    = EXC_STORE_PAGE_FAULT;
    bus.exc_pc      = 64'h8000_0300;
    bus.exc_tval    = 64'hDEAD_BEEF;
    expect_trap(c0, 64'h8000_0300, 64'd15, 64'hDEAD_BEEF, 64'h1800, 64'h8000_0100, 3);
    nxt();
    clr_req();
    nxt();
    bus.csr_wready = 1'b0;
    hold_addr      = 12'h342;
    hold_data      = 64'd15;
    hold_chk       = 1'b1;
    repeat (3) nxt();
    bus.csr_wready = 1'b1;
    hold_chk       = 1'b0;
    wait_idle();

    // Reset during W_MTVAL: only mepc/mcause writes, no redirect afterwards.
    c0 = cyc;
    bus.csr_mstatus = 64'h8;
    bus.exc_valid   = 1'b1;
    bus.exc_code    = EXC_LOAD_ACCESS;
    bus.exc_pc      = 64'h8000_0500;
    bus.exc_tval    = 64'h40;
    push(12'h341, 64'h8000_0500, 2'b00, c0 + 1);
    push(12'h342, 64'd5, 2'b00, c0 + 2);
    nxt();
    clr_req();
    nxt();
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    repeat (10) nxt();

    // External interrupt, mtvec mode bits 01.
    c0 = cyc;
    bus.csr_mstatus = 64'h8;
    bus.csr_mtvec   = 64'h8000_0101;
    bus.irq_valid   = 1'b1;
    bus.irq_cause   = EXINTPROCESSING;
    bus.irq_pc      = 64'h8000_0600;
`ifdef TRAP_VECTORED_EN
    expect_trap(c0, 64'h8000_0600, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 64'h8000_012C, 0);
`else
    expect_trap(c0, 64'h8000_0600, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 64'h8000_0100, 0);
`endif
    nxt();
    clr_req();
    wait_idle();

    // Software interrupt, mtvec mode bits 01.
    c0 = cyc;
    bus.csr_mstatus = 64'h8;
    bus.irq_valid   = 1'b1;
    bus.irq_cause   = SWINTPROCESSING;
    bus.irq_pc      = 64'h8000_0700;
`ifdef TRAP_VECTORED_EN
    expect_trap(c0, 64'h8000_0700, 64'h8000_0000_0000_0003, 64'd0, 64'h1880, 64'h8000_010C, 0);
`else
    expect_trap(c0, 64'h8000_0700, 64'h8000_0000_0000_0003, 64'd0, 64'h1880, 64'h8000_0100, 0);
`endif
    nxt();
    clr_req();
    wait_idle();

    repeat (3) nxt();
    done = 1'b1;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port exc_valid/exc_code/exc_pc/exc_tval  input  1/4/64/64  synchronous exception request; code is exception_code_t.
REQ-004 SHALL have port irq_valid/irq_cause/irq_pc  input  1/4/64  interrupt request; cause is interrupt_trap_cause_t.
REQ-005 SHALL have port mret_valid  input  1  mret retiring.
REQ-006 SHALL have port csr_mstatus/csr_mtvec/csr_mepc  input  64 each  current CSR values.
REQ-007 SHALL have port csr_we/csr_waddr/csr_wdata  output  1/12/64  CSR write request.
REQ-008 SHALL have port csr_wready  input  1  CSR file accepts the write this cycle.
REQ-009 SHALL have port busy/flush/redirect_valid/redirect_pc  output  1/1/1/64  pipeline stall, flush, PC redirect.
REQ-010 SHALL have port priv_mode  output  2  current privilege (11=M, 00=U).

Function
REQ-011 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, REDIRECT.
REQ-012 SHALL sample requests only in IDLE; priority exception > interrupt > mret; losers ignored, requesters hold until busy deasserts.
REQ-013 SHALL treat exc_valid with exc_code=EXC_NONE as no request.
REQ-014 SHALL accept irq_valid only when csr_mstatus[3] (MIE)=1.
REQ-015 SHALL, on accepted trap, latch pc, cause, tval (0 for interrupts) and go IDLE->W_MEPC->W_MCAUSE->W_MTVAL->W_MSTATUS->REDIRECT->IDLE.
REQ-016 SHALL, on accepted mret, go IDLE->R_MSTATUS->REDIRECT->IDLE.
REQ-017 SHALL in each W_*/R_* state drive csr_we=1 with waddr 341/342/343/300 (hex), hold addr/data stable, and advance only in a cycle with csr_wready=1.
REQ-018 SHALL map mcause for exception codes 1-8 to code-1; 9->8, 11->11, 12->12, 13->13, 14->15; bit63=0.
REQ-019 SHALL map interrupt mcause: SWINTPROCESSING->3, TRINTPROCESSING->7, EXINTPROCESSING->11; bit63=1.
REQ-020 SHALL on trap write mstatus with MPIE<-MIE, MIE<-0, MPP<-priv_mode, all other bits unchanged, and set priv_mode=11 in the REDIRECT cycle.
REQ-021 SHALL on mret write mstatus with MIE<-MPIE, MPIE<-1, MPP<-00, and set priv_mode<-old MPP in the REDIRECT cycle.
REQ-022 SHALL in REDIRECT pulse redirect_valid=1 and flush=1 for exactly one cycle; redirect_pc = {mtvec[63:2],2'b00} for trap, csr_mepc for mret.
REQ-023 SHALL drive busy=1 whenever state!=IDLE, combinationally from state.
REQ-024 SHALL give latency with csr_wready tied high: trap accept edge to redirect_valid = 5 cycles; mret = 2 cycles.

Reset
REQ-025 SHALL on rst_n=0, immediately and independent of clk, force state=IDLE, csr_we=0, busy=0, flush=0, redirect_valid=0, redirect_pc=0, csr_waddr=0, csr_wdata=0, priv_mode=11.
REQ-026 SHALL on reset mid-sequence abandon pending writes and emit no redirect after reset release.

Configuration
REQ-027 SHALL, with TRAP_VECTORED_EN defined and mtvec[1:0]=01, use redirect_pc = base + 4*mcause[62:0] for interrupts; exceptions still use base.
REQ-028 SHALL, without TRAP_VECTORED_EN, ignore mtvec[1:0] and always use direct mode.

Verification
REQ-029 SHALL cover exc EXC_ILLEGAL_INST, pc=0x8000_0010, tval=0x1234, mtvec=0x8000_0100, MIE=1, priv=11 -> writes mepc=0x8000_0010, mcause=2, mtval=0x1234, mstatus MIE=0/MPIE=1/MPP=11; redirect_pc=0x8000_0100 at cycle 5.
REQ-030 SHALL cover irq TRINTPROCESSING with MIE=0 -> no write, busy stays 0; with MIE=1 -> mcause=0x8000_0000_0000_0007.
REQ-031 SHALL cover exc, irq and mret asserted together -> exception sequence only.
REQ-032 SHALL cover csr_wready low 3 cycles in W_MCAUSE -> waddr=342 held stable, redirect at cycle 8.
REQ-033 SHALL cover mret with mepc=0x8000_2000, MPP=00, MPIE=1 -> mstatus MIE=1/MPP=00, priv_mode=00, redirect_pc=0x8000_2000 at cycle 2.
REQ-034 SHALL cover rst_n low during W_MTVAL -> csr_we=0 same cycle, no redirect_valid after release; with TRAP_VECTORED_EN, EXINTPROCESSING and mtvec=0x8000_0101 -> redirect_pc=0x8000_012C.
